// File: rtl/cic_uart_tx.sv
// rtl/cic_uart_tx.sv - buffers decimated CIC samples and sends each one as an 8N1 UART frame
//
// Ports:
//   clk        in   system clock, shared with the decimator
//   rst        in   synchronous reset, active-high
//   dwn_clk    in   decimator sample clock; a rising edge marks a new sample
//   data       in   DATA_W-bit decimated sample, stable when dwn_clk rises
//   enable     in   1 = capture samples, 0 = ignore new samples but drain the FIFO
//   tx         out  UART serial line, idle high
//   busy       out  frame in flight or FIFO non-empty
//   overflow   out  sticky: a sample was dropped because the FIFO was full
//   fifo_level out  current FIFO occupancy
module cic_uart_tx #(
    parameter int DATA_W       = 6,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dwn_clk,
    input  logic [DATA_W-1:0]           data,
    input  logic                        enable,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              dwn_prev_q;
    logic              overflow_q;

    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              busy_q;

    logic              strobe;
    logic              push;
    logic              pop;
    logic              accept;
    logic              baud_last;
    logic [7:0]        head_byte;

    assign strobe    = dwn_clk & ~dwn_prev_q;
    assign push      = strobe & enable;
    assign pop       = (state_q == S_IDLE) && (level_q != '0);
    // A full FIFO still accepts when the head leaves in the same cycle; the
    // write slot then equals the read slot, but the read sees the old entry.
    assign accept    = push && ((level_q < LVL_W'(FIFO_DEPTH)) || pop);
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign head_byte = 8'(mem_q[rd_ptr_q]);

    always_comb begin
        level_d = level_q;
        if (accept && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!accept && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            // Held high so a dwn_clk already high at reset release is not an edge.
            dwn_prev_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            dwn_prev_q <= dwn_clk;
            level_q    <= level_d;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // tx and busy are registered from the current state, so the line lags the
    // state by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_q != S_IDLE) || (level_q != '0);
            case (state_q)
                S_START: tx_q <= 1'b0;
                S_DATA:  tx_q <= shift_q[0];
                default: tx_q <= 1'b1;
            endcase

            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= head_byte;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_cic_uart_tx.sv
// tb/tb_cic_uart_tx.sv - self-checking bench for cic_uart_tx
module tb_cic_uart_tx;

    localparam int DW    = 6;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          dwn_clk;
    logic [DW-1:0] data;
    logic          enable;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    cic_uart_tx #(
        .DATA_W(DW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dwn_clk(dwn_clk),
        .data(data),
        .enable(enable),
        .tx(tx),
        .busy(busy),
        .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference schedule: edge of each accepted push, edge of its pop, its byte.
    int         push_q[$];
    int         pop_q[$];
    logic [7:0] byte_q[$];
    bit         m_prev = 1'b1;
    bit         m_ovf  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_level(input int n);
        int c = 0;
        foreach (push_q[i]) if (push_q[i] <= n) c++;
        foreach (pop_q[i]) if (pop_q[i] <= n) c--;
        return c;
    endfunction

    // Frame state (START..STOP) occupies the FRAME edges starting at the pop edge.
    function automatic bit m_active(input int m);
        foreach (pop_q[i]) if (m >= pop_q[i] && m <= pop_q[i] + FRAME - 1) return 1'b1;
        return 1'b0;
    endfunction

    // The line shows the frame one edge after the state: bit slot b of 10.
    function automatic bit m_tx(input int n);
        foreach (pop_q[i]) begin
            if (n >= pop_q[i] + 1 && n <= pop_q[i] + FRAME) begin
                int         b = (n - pop_q[i] - 1) / CPB;
                logic [7:0] v = byte_q[i];
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return v[b-1];
            end
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input int n);
        if (rst) begin
            push_q.delete();
            pop_q.delete();
            byte_q.delete();
            m_prev = 1'b1;
            m_ovf  = 1'b0;
        end else begin
            bit strobe = dwn_clk & ~m_prev;
            m_prev = dwn_clk;
            if (strobe && enable) begin
                int lvl     = m_level(n - 1);
                bit pop_now = 1'b0;
                foreach (pop_q[i]) if (pop_q[i] == n) pop_now = 1'b1;
                if (lvl < DEPTH || pop_now) begin
                    int p = n + 1;
                    if (pop_q.size() > 0 && pop_q[$] + FRAME + 1 > p) p = pop_q[$] + FRAME + 1;
                    push_q.push_back(n);
                    pop_q.push_back(p);
                    byte_q.push_back(8'(data));
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        logic [5:0] exp;
        @(posedge clk);
        cyc++;
        model_edge(cyc);
        #1;
        exp = {m_tx(cyc), (m_active(cyc - 1) || m_level(cyc - 1) != 0), m_ovf, LW'(m_level(cyc))};
        chk("cycle_model{tx,busy,ovf,level}", int'({tx, busy, overflow, fifo_level}), int'(exp));
    endtask

    // Line decoder: samples each bit one cycle into its slot.
    int         rx_o = -1;
    int         rx_start = 0;
    logic [9:0] rx_bits = '1;
    logic [9:0] rx_frames[$];
    int         rx_starts[$];

    always @(negedge clk) begin
        if (rst) begin
            rx_o = -1;
        end else if (rx_o < 0) begin
            if (tx === 1'b0) begin
                rx_o     = 0;
                rx_start = cyc;
            end
        end else begin
            rx_o = rx_o + 1;
            if (rx_o % CPB == 1) rx_bits[rx_o / CPB] = tx;
            if (rx_o == FRAME - 1) begin
                rx_frames.push_back(rx_bits);
                rx_starts.push_back(rx_start);
                rx_o = -1;
            end
        end
    end

    typedef struct {
        logic [5:0] d;
        bit         en;
        bit         sent;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    task automatic strobe_burst(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            data    = DW'(first + i);
            dwn_clk = 1'b1;
            step();
            dwn_clk = 1'b0;
            step();
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        while (busy && k < bound) begin
            step();
            k++;
        end
        chk(name, int'(busy), 0);
    endtask

    task automatic check_bytes(input string name, input int base, input int n, input int first);
        logic [9:0] f;
        chk({name, "_count"}, rx_frames.size() - base, n);
        for (int i = 0; i < n && base + i < rx_frames.size(); i++) begin
            f = rx_frames[base + i];
            chk({name, "_byte"}, int'(f[8:1]), first + i);
            chk({name, "_framing"}, int'({f[9], f[0]}), 2);
            if (i > 0) chk({name, "_spacing"}, rx_starts[base + i] - rx_starts[base + i - 1], FRAME + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int t0;
        int peak;
        int lows;
        int base;
        int rate;

        vecs[0] = '{6'h2D, 1'b1, 1'b1, {1'b1, 8'h2D, 1'b0}};
        vecs[1] = '{6'h3F, 1'b1, 1'b1, {1'b1, 8'h3F, 1'b0}};
        vecs[2] = '{6'h00, 1'b1, 1'b1, {1'b1, 8'h00, 1'b0}};
        vecs[3] = '{6'h15, 1'b0, 1'b0, 10'h3FF};
        vecs[4] = '{6'h2A, 1'b1, 1'b1, {1'b1, 8'h2A, 1'b0}};

        // Reset held with dwn_clk high: no false edge on release.
        rst = 1'b1; dwn_clk = 1'b1; enable = 1'b1; data = '0;
        repeat (3) step();
        rst  = 1'b0;
        lows = 0;
        repeat (50) begin
            step();
            if (tx == 1'b0) lows++;
        end
        chk("reset_no_frame", lows, 0);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_level", int'(fifo_level), 0);
        dwn_clk = 1'b0;
        step();

        // Single samples from the table.
        for (int v = 0; v < 5; v++) begin
            base    = rx_frames.size();
            data    = vecs[v].d;
            enable  = vecs[v].en;
            dwn_clk = 1'b1;
            step();
            dwn_clk = 1'b0;
            k = 1;
            while (tx && k < 12) begin
                step();
                k++;
            end
            if (vecs[v].sent) begin
                chk("vec_latency", k, 3);
                t0 = cyc;
                wait_idle("vec_idle", 60);
                chk("vec_frame_len", cyc - t0, FRAME);
                chk("vec_count", rx_frames.size() - base, 1);
                if (rx_frames.size() > base) chk("vec_frame", int'(rx_frames[base]), int'(vecs[v].frame));
            end else begin
                repeat (40) step();
                chk("gated_count", rx_frames.size() - base, 0);
                chk("gated_level", int'(fifo_level), 0);
                chk("gated_ovf", int'(overflow), 0);
            end
            enable = 1'b1;
            repeat (5) step();
        end

        // Burst of four, two cycles apart.
        base = rx_frames.size();
        peak = 0;
        for (int i = 1; i <= 4; i++) begin
            data = DW'(i); dwn_clk = 1'b1;
            step();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            dwn_clk = 1'b0;
            step();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        wait_idle("burst_idle", 300);
        chk("burst_peak_3_or_4", int'(peak == 3 || peak == 4), 1);
        check_bytes("burst", base, 4, 1);
        chk("burst_ovf", int'(overflow), 0);
        repeat (5) step();

        // Six quick samples: five fit (one leaves immediately), the sixth drops.
        base = rx_frames.size();
        strobe_burst(6, 10);
        chk("ovf_set", int'(overflow), 1);
        wait_idle("ovf_idle", 400);
        check_bytes("ovf", base, 5, 10);
        repeat (60) step();
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_no_sixth", rx_frames.size() - base, 5);

        // Enable gating after a clearing reset.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_clears_ovf", int'(overflow), 0);
        base   = rx_frames.size();
        enable = 1'b0;
        strobe_burst(8, 3);
        repeat (30) step();
        chk("disabled_level", int'(fifo_level), 0);
        chk("disabled_ovf", int'(overflow), 0);
        chk("disabled_count", rx_frames.size() - base, 0);
        enable = 1'b1;
        strobe_burst(2, 6'h11 - 0);
        repeat (10) step();
        enable = 1'b0;
        wait_idle("drain_idle", 300);
        check_bytes("drain", base, 2, 6'h11);
        enable = 1'b1;
        repeat (5) step();

        // Reset during data bit 3 with two entries queued.
        base = rx_frames.size();
        strobe_burst(3, 5);
        k = 0;
        while (cyc < rx_start + 16 && k < 50) begin
            step();
            k++;
        end
        chk("midrst_queued", int'(fifo_level), 2);
        chk("midrst_in_frame", int'(busy), 1);
        rst = 1'b1;
        step();
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_level", int'(fifo_level), 0);
        rst  = 1'b0;
        lows = 0;
        repeat (100) begin
            step();
            if (tx == 1'b0) lows++;
        end
        chk("midrst_no_frames", lows, 0);
        chk("midrst_busy", int'(busy), 0);

        // Randomized traffic against the reference schedule.
        for (int i = 0; i < 2400; i++) begin
            rate    = ((i / 600) % 2 == 1) ? 45 : 4;
            rst     = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            dwn_clk = ($urandom_range(0, 99) < rate);
            data    = DW'($urandom);
            step();
        end
        rst = 1'b0; dwn_clk = 1'b0; enable = 1'b1;
        wait_idle("random_drain", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
